// File: rtl/rom_port_arbiter.sv
// Two-port arbiter (instruction fetch, load unit) in front of the combinational boot ROM read port.
// Each port gets range-checked, registered 32-bit responses exactly one cycle after its grant.
module rom_port_arbiter #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] BASE       = 32'hBFC00000,
  parameter int               SIZE       = 4096,
  parameter int               STARVE_MAX = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             if_req_i,
  input  logic [WIDTH-1:0] if_addr_i,
  output logic             if_gnt_o,
  output logic             if_rvalid_o,
  output logic [WIDTH-1:0] if_rdata_o,
  output logic             if_err_o,
  input  logic             ld_req_i,
  input  logic [WIDTH-1:0] ld_addr_i,
  output logic             ld_gnt_o,
  output logic             ld_rvalid_o,
  output logic [WIDTH-1:0] ld_rdata_o,
  output logic             ld_err_o,
  output logic [WIDTH-1:0] rom_addr_o,
  input  logic [WIDTH-1:0] rom_data_i
);

  localparam int                SW    = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     SMAX  = SW'(STARVE_MAX);
  localparam logic [WIDTH:0]    WIN_LO = {1'b0, BASE};
  localparam logic [WIDTH:0]    WIN_HI = {1'b0, BASE} + (WIDTH+1)'(SIZE - 1);

  // One extra bit keeps addr+3 from wrapping back into the window near the top of memory.
  function automatic logic in_range(input logic [WIDTH-1:0] addr);
    logic [WIDTH:0] ext;
    ext = {1'b0, addr};
    return (ext >= WIN_LO) && ((ext + (WIDTH+1)'(3)) <= WIN_HI);
  endfunction

  logic [SW-1:0]    starve_q, starve_d;
  logic             if_rvalid_q, if_rvalid_d;
  logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic             if_err_q, if_err_d;
  logic             ld_rvalid_q, ld_rvalid_d;
  logic [WIDTH-1:0] ld_rdata_q, ld_rdata_d;
  logic             ld_err_q, ld_err_d;

  logic             if_prio;
  logic             gnt_any;
  logic             gnt_ok;
  logic [WIDTH-1:0] gnt_addr;
  logic [WIDTH-1:0] resp_data;

  always_comb begin
    if_prio   = (starve_q == SMAX);
    if_gnt_o  = rst_n_i & if_req_i & (if_prio | ~ld_req_i);
    ld_gnt_o  = rst_n_i & ld_req_i & ~(if_req_i & if_prio);
    gnt_any   = if_gnt_o | ld_gnt_o;
    gnt_addr  = if_gnt_o ? if_addr_i : ld_addr_i;
    gnt_ok    = in_range(gnt_addr);
    // Out-of-range or idle cycles park the ROM index at the window base.
    rom_addr_o = (gnt_any && gnt_ok) ? gnt_addr : BASE;
    resp_data  = gnt_ok ? rom_data_i : '0;

    if (!if_req_i || if_gnt_o) begin
      starve_d = '0;
    end else if (starve_q != SMAX) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end

    if_rvalid_d = if_gnt_o;
    if_rdata_d  = if_gnt_o ? resp_data : if_rdata_q;
    if_err_d    = if_gnt_o ? ~gnt_ok   : if_err_q;
    ld_rvalid_d = ld_gnt_o;
    ld_rdata_d  = ld_gnt_o ? resp_data : ld_rdata_q;
    ld_err_d    = ld_gnt_o ? ~gnt_ok   : ld_err_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      ld_rvalid_q <= 1'b0;
      ld_rdata_q  <= '0;
      ld_err_q    <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      ld_rvalid_q <= ld_rvalid_d;
      ld_rdata_q  <= ld_rdata_d;
      ld_err_q    <= ld_err_d;
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_err_o    = if_err_q;
  assign ld_rvalid_o = ld_rvalid_q;
  assign ld_rdata_o  = ld_rdata_q;
  assign ld_err_o    = ld_err_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed vector table, hand-written multi-cycle sequences,
// then random traffic against a behavioural arbitration/ROM model.
module tb_rom_port_arbiter;

  localparam int          WIDTH      = 32;
  localparam logic [31:0] BASE       = 32'hBFC00000;
  localparam int          SIZE       = 4096;
  localparam int          STARVE_MAX = 3;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        if_req_i, ld_req_i;
  logic [31:0] if_addr_i, ld_addr_i;
  logic        if_gnt_o, ld_gnt_o;
  logic        if_rvalid_o, ld_rvalid_o;
  logic [31:0] if_rdata_o, ld_rdata_o;
  logic        if_err_o, ld_err_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;

  rom_port_arbiter #(
    .WIDTH(WIDTH), .BASE(BASE), .SIZE(SIZE), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_gnt_o(ld_gnt_o),
    .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o), .ld_err_o(ld_err_o),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] rom [0:SIZE-1];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    longint off;
    int     i;
    off = longint'(addr) - longint'(BASE);
    if (off < 0 || off > SIZE - 4) return 32'hDEADBEEF;
    i = int'(off);
    return {rom[i+3], rom[i+2], rom[i+1], rom[i]};
  endfunction

  always_comb rom_data_i = rom_word(rom_addr_o);

  function automatic logic window_ok(input logic [31:0] addr);
    longint a;
    a = longint'(addr);
    return (a >= longint'(BASE)) && (a + 3 <= longint'(BASE) + SIZE - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Drive a request pair just after the falling edge and let combinational outputs settle.
  task automatic step(input logic ir, input logic [31:0] ia, input logic lr, input logic [31:0] la);
    @(negedge clk_i);
    if_req_i = ir; if_addr_i = ia; ld_req_i = lr; ld_addr_i = la;
    #1;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic ir; logic [31:0] ia; logic lr; logic [31:0] la;
    logic eig; logic elg; logic [31:0] era;
    logic eirv; logic [31:0] eid; logic eie;
    logic elrv; logic [31:0] eld; logic ele;
  } vec_t;

  function automatic vec_t mkv(input logic ir, input logic [31:0] ia, input logic lr, input logic [31:0] la,
                               input logic eig, input logic elg, input logic [31:0] era,
                               input logic eirv, input logic [31:0] eid, input logic eie,
                               input logic elrv, input logic [31:0] eld, input logic ele);
    vec_t v;
    v.ir = ir; v.ia = ia; v.lr = lr; v.la = la;
    v.eig = eig; v.elg = elg; v.era = era;
    v.eirv = eirv; v.eid = eid; v.eie = eie;
    v.elrv = elrv; v.eld = eld; v.ele = ele;
    return v;
  endfunction

  vec_t vecs [8];

  initial begin
    logic [31:0] w_ffc, w_2;
    logic [31:0] a_if, a_ld;
    int          m_starve;
    logic        m_irv, m_ie, m_lrv, m_le;
    logic [31:0] m_id, m_ld;

    for (int i = 0; i < SIZE; i++) rom[i] = 8'((i * 37 + 11) & 8'hFF);
    rom[0] = 8'h13; rom[1] = 8'h05; rom[2] = 8'h00; rom[3] = 8'h00;
    w_ffc = {rom[SIZE-1], rom[SIZE-2], rom[SIZE-3], rom[SIZE-4]};
    w_2   = {rom[5], rom[4], rom[3], rom[2]};

    vecs[0] = mkv(1, BASE,          0, 0,             1, 0, BASE,          1, 32'h00000513, 0, 0, 0, 0);
    vecs[1] = mkv(0, 0,             1, 32'hBFC00FFC,  0, 1, 32'hBFC00FFC,  0, 32'h00000513, 0, 1, w_ffc, 0);
    vecs[2] = mkv(0, 0,             1, 32'hBFC00FFD,  0, 1, BASE,          0, 32'h00000513, 0, 1, 0, 1);
    vecs[3] = mkv(0, 0,             1, 32'hBFBFFFFF,  0, 1, BASE,          0, 32'h00000513, 0, 1, 0, 1);
    vecs[4] = mkv(0, 0,             1, 32'hFFFFFFFE,  0, 1, BASE,          0, 32'h00000513, 0, 1, 0, 1);
    vecs[5] = mkv(1, 32'hBFC00002,  0, 0,             1, 0, 32'hBFC00002,  1, w_2, 0,          0, 0, 1);
    vecs[6] = mkv(1, 32'h00000000,  0, 0,             1, 0, BASE,          1, 0, 1,            0, 0, 1);
    vecs[7] = mkv(0, 0,             0, 0,             0, 0, BASE,          0, 0, 1,            0, 0, 1);

    // Reset with both requests high: nothing may be granted.
    rst_n_i = 1'b0; if_req_i = 1'b1; ld_req_i = 1'b1; if_addr_i = BASE; ld_addr_i = BASE;
    #1;
    chk("rst if_gnt", 32'(if_gnt_o), 0);
    chk("rst ld_gnt", 32'(ld_gnt_o), 0);
    chk("rst rom_addr", rom_addr_o, BASE);
    tick(); tick();
    chk("rst if_rvalid", 32'(if_rvalid_o), 0);
    chk("rst ld_rvalid", 32'(ld_rvalid_o), 0);
    chk("rst if_rdata", if_rdata_o, 0);
    chk("rst ld_rdata", ld_rdata_o, 0);
    chk("rst if_err", 32'(if_err_o), 0);
    chk("rst ld_err", 32'(ld_err_o), 0);
    @(negedge clk_i);
    rst_n_i = 1'b1; if_req_i = 1'b0; ld_req_i = 1'b0;

    // Directed vector table.
    for (int k = 0; k < 8; k++) begin
      step(vecs[k].ir, vecs[k].ia, vecs[k].lr, vecs[k].la);
      chk($sformatf("v%0d if_gnt", k), 32'(if_gnt_o), 32'(vecs[k].eig));
      chk($sformatf("v%0d ld_gnt", k), 32'(ld_gnt_o), 32'(vecs[k].elg));
      chk($sformatf("v%0d rom_addr", k), rom_addr_o, vecs[k].era);
      tick();
      chk($sformatf("v%0d if_rvalid", k), 32'(if_rvalid_o), 32'(vecs[k].eirv));
      chk($sformatf("v%0d if_rdata", k), if_rdata_o, vecs[k].eid);
      chk($sformatf("v%0d if_err", k), 32'(if_err_o), 32'(vecs[k].eie));
      chk($sformatf("v%0d ld_rvalid", k), 32'(ld_rvalid_o), 32'(vecs[k].elrv));
      chk($sformatf("v%0d ld_rdata", k), ld_rdata_o, vecs[k].eld);
      chk($sformatf("v%0d ld_err", k), 32'(ld_err_o), 32'(vecs[k].ele));
    end

    // Both ports request every cycle: LD,LD,LD,IF repeating.
    a_if = BASE + 32'h10; a_ld = BASE + 32'h20;
    for (int k = 0; k < 8; k++) begin
      logic exp_if;
      exp_if = (k % 4 == 3);
      step(1, a_if, 1, a_ld);
      chk($sformatf("rr%0d if_gnt", k), 32'(if_gnt_o), 32'(exp_if));
      chk($sformatf("rr%0d ld_gnt", k), 32'(ld_gnt_o), 32'(!exp_if));
      chk($sformatf("rr%0d rom_addr", k), rom_addr_o, exp_if ? a_if : a_ld);
      tick();
      chk($sformatf("rr%0d if_rvalid", k), 32'(if_rvalid_o), 32'(exp_if));
      chk($sformatf("rr%0d ld_rvalid", k), 32'(ld_rvalid_o), 32'(!exp_if));
      if (exp_if) chk($sformatf("rr%0d if_rdata", k), if_rdata_o, rom_word(a_if));
      else        chk($sformatf("rr%0d ld_rdata", k), ld_rdata_o, rom_word(a_ld));
    end

    // IF drops its request after two denials; the starvation count must restart.
    step(0, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      logic ir;
      ir = (k != 2);
      step(ir, a_if, 1, a_ld);
      chk($sformatf("drop%0d if_gnt", k), 32'(if_gnt_o), 32'(k == 6));
      chk($sformatf("drop%0d ld_gnt", k), 32'(ld_gnt_o), 32'(k != 6));
    end

    // Build full starvation, then reset asynchronously in the cycle IF is granted.
    step(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(1, a_if, 1, a_ld);
    step(1, a_if, 1, a_ld);
    chk("prerst if_gnt", 32'(if_gnt_o), 1);
    #1 rst_n_i = 1'b0;
    #1;
    chk("midrst if_gnt", 32'(if_gnt_o), 0);
    chk("midrst ld_gnt", 32'(ld_gnt_o), 0);
    chk("midrst rom_addr", rom_addr_o, BASE);
    chk("midrst ld_rvalid", 32'(ld_rvalid_o), 0);
    chk("midrst ld_rdata", ld_rdata_o, 0);
    tick();
    chk("postrst if_rvalid", 32'(if_rvalid_o), 0);
    chk("postrst if_rdata", if_rdata_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("release ld_gnt", 32'(ld_gnt_o), 1);
    chk("release if_gnt", 32'(if_gnt_o), 0);
    tick();
    chk("release ld_rvalid", 32'(ld_rvalid_o), 1);
    chk("release ld_rdata", ld_rdata_o, rom_word(a_ld));

    // Random traffic against the behavioural model, starting from a fresh reset.
    @(negedge clk_i);
    rst_n_i = 1'b0; if_req_i = 1'b0; ld_req_i = 1'b0;
    #2 rst_n_i = 1'b1;
    m_starve = 0;
    m_irv = 0; m_id = 0; m_ie = 0; m_lrv = 0; m_ld = 0; m_le = 0;
    for (int k = 0; k < 400; k++) begin
      logic        ir, lr, wi, wl;
      logic [31:0] ia, la, ga, era;
      ir = ($urandom_range(0, 3) != 0);
      lr = ($urandom_range(0, 3) != 0);
      ia = pick_addr();
      la = pick_addr();
      step(ir, ia, lr, la);
      if (ir && lr) begin
        wi = (m_starve >= STARVE_MAX);
        wl = !wi;
      end else begin
        wi = ir;
        wl = lr;
      end
      ga  = wi ? ia : la;
      era = ((wi || wl) && window_ok(ga)) ? ga : BASE;
      chk($sformatf("rnd%0d if_gnt", k), 32'(if_gnt_o), 32'(wi));
      chk($sformatf("rnd%0d ld_gnt", k), 32'(ld_gnt_o), 32'(wl));
      chk($sformatf("rnd%0d rom_addr", k), rom_addr_o, era);
      m_irv = wi; m_lrv = wl;
      if (wi) begin m_id = window_ok(ia) ? rom_word(ia) : 0; m_ie = !window_ok(ia); end
      if (wl) begin m_ld = window_ok(la) ? rom_word(la) : 0; m_le = !window_ok(la); end
      if (!ir || wi) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
      tick();
      chk($sformatf("rnd%0d if_rvalid", k), 32'(if_rvalid_o), 32'(m_irv));
      chk($sformatf("rnd%0d if_rdata", k), if_rdata_o, m_id);
      chk($sformatf("rnd%0d if_err", k), 32'(if_err_o), 32'(m_ie));
      chk($sformatf("rnd%0d ld_rvalid", k), 32'(ld_rvalid_o), 32'(m_lrv));
      chk($sformatf("rnd%0d ld_rdata", k), ld_rdata_o, m_ld);
      chk($sformatf("rnd%0d ld_err", k), 32'(ld_err_o), 32'(m_le));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return BASE + 32'($urandom_range(0, SIZE - 4));
      3:       return BASE + 32'(SIZE - 4) + 32'($urandom_range(0, 6));
      4:       return BASE - 32'($urandom_range(1, 4));
      default: return $urandom;
    endcase
  endfunction

endmodule
